multicycle_ctrl: RTL and testbench

Finite-state sequencer that drives the MIPS-subset datapath (regfile, ALU, unified memory, PC, IR, muxes) as a multi-cycle machine. It decodes the IR opcode/funct fields and issues per-cycle mux selects, write enables and ALU control. It waits on a memory ready handshake with a timeout, and counts retired instructions. It replaces the single-cycle `control` block.

---
 rtl/multicycle_ctrl_if.sv | 55 +++++
 rtl/multicycle_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Groups the controller <-> datapath signals of the multi-cycle MIPS-subset
//   machine into one bundle.
//
//   Handshake: mem_read / mem_write (with i_or_d) are held high for every
//   cycle the controller sits in a memory state. The memory raises mem_ready
//   in the cycle the access completes. The controller advances on the clock
//   edge that ends a cycle in which mem_ready was high. There is no separate
//   request/accept pair: the strobe acts as valid and mem_ready acts as ready.
//
//   Signals
//     start          datapath -> ctrl  one-cycle run pulse (honoured in IDLE only)
//     opcode, funct  datapath -> ctrl  IR[31:26], IR[5:0]
//     mem_ready      memory   -> ctrl  current access completes this cycle
//     mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
//     reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
//     pc_source      ctrl     -> datapath  per-cycle controls
//
//   Modports
//     master  the controller
//     slave   the datapath / memory side
interface multicycle_ctrl_if;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_source;

    modport master (
        input  start, opcode, funct, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, pc_source
    );

    modport slave (
        output start, opcode, funct, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, pc_source
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Finite-state sequencer for the multi-cycle MIPS-subset datapath
//   (add/sub/and/or/slt, lw, sw, beq, j, addi). It decodes the IR fields,
//   issues per-cycle mux selects, write enables and ALU control, and waits
//   on the memory ready handshake with a bounded wait. It also counts
//   retired instructions and keeps sticky illegal-instruction and timeout
//   flags.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high
//     bus          multicycle_ctrl_if.master (start/IR fields/mem_ready in,
//                  datapath controls out)
//     state        current state encoding (debug)
//     instr_count  retired instruction count, wraps at 16 bits
//     err_illegal  sticky: undecodable opcode or R-type funct seen
//     err_timeout  sticky: memory did not answer within TIMEOUT cycles
//
//   Parameter
//     TIMEOUT      consecutive mem_ready-low cycles allowed in a memory
//                  state before giving up (1..15)
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus,
    output logic [3:0]        state,
    output logic [15:0]       instr_count,
    output logic              err_illegal,
    output logic              err_timeout
);

    // ------------------------------------------------------------------
    // State encoding (fixed, also visible on the debug port)
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_RWB     = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JUMP    = 4'd10;
    localparam logic [3:0] S_ADDI_EX = 4'd11;
    localparam logic [3:0] S_ADDI_WB = 4'd12;
    localparam logic [3:0] S_HALT    = 4'd13;

    // Opcodes and R-type function codes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC sources
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Wait count value seen during the last permitted low cycle.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [3:0]  wait_cnt;
    logic [15:0] count_q;
    logic        err_illegal_q;
    logic        err_timeout_q;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic rfunct_ok;
    logic is_rtype_ok;
    logic is_mem;
    logic is_sw;

    always_comb begin
        rfunct_ok = 1'b0;
        case (bus.funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: rfunct_ok = 1'b1;
            default:                               rfunct_ok = 1'b0;
        endcase
    end

    assign is_rtype_ok = (bus.opcode == OP_RTYPE) && rfunct_ok;
    assign is_mem      = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign is_sw       = (bus.opcode == OP_SW);

    // R-type funct to ALU operation. Only reached with a legal funct;
    // ADD is a harmless fallback.
    logic [3:0] rtype_alu;

    always_comb begin
        rtype_alu = ALU_ADD;
        case (bus.funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory wait tracking
    // ------------------------------------------------------------------
    logic in_wait_state;
    logic wait_expired;

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                           (state_q == S_MEMWR);

    // A ready in the final permitted cycle still counts as success, so
    // expiry needs mem_ready low.
    assign wait_expired = in_wait_state && !bus.mem_ready &&
                          (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic retire;
    logic illegal_hit;
    logic timeout_hit;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_rtype_ok) begin
                    state_d = S_EXEC;
                end else if (is_mem) begin
                    state_d = S_MEMADR;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (bus.opcode == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else begin
                    state_d     = S_HALT;
                    illegal_hit = 1'b1;
                end
            end
            S_MEMADR: begin
                // IR is stable here; only lw/sw can reach this state.
                state_d = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt      <= 4'd0;
            count_q       <= 16'd0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // Counting only while stalled keeps the counter at zero on
            // every entry to a memory state.
            if (in_wait_state && !bus.mem_ready && !wait_expired) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end

            if (retire)      count_q       <= count_q + 16'd1;
            if (illegal_hit) err_illegal_q <= 1'b1;
            if (timeout_hit) err_timeout_q <= 1'b1;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

    // ------------------------------------------------------------------
    // Control outputs: decoded from registered state (and IR for EXEC).
    // Only ir_write/pc_write in FETCH look at mem_ready, so the IR and PC
    // load exactly once, on the cycle the fetch completes.
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dest      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_ctrl      = ALU_AND;
        bus.pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.alu_ctrl  = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target PC+4+(imm<<2) lands in ALUOut.
                bus.alu_src_b = SRCB_IMMSH;
                bus.alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = rtype_alu;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_ctrl      = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                bus.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        err_illegal;
  logic        err_timeout;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .state       (state),
    .instr_count (instr_count),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  // Spec state numbers
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                 S_MEMRD = 4, S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7,
                 S_RWB = 8, S_BRANCH = 9, S_JUMP = 10, S_ADDI_EX = 11,
                 S_ADDI_WB = 12, S_HALT = 13;

  // All datapath controls as one vector for comparison
  logic [17:0] ctrl_vec;
  assign ctrl_vec = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                     bus.pc_write, bus.pc_write_cond, bus.reg_write,
                     bus.reg_dest, bus.mem_to_reg, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_ctrl, bus.pc_source};

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];      // expected state per cycle
  logic       exp_rdy_q[$];  // mem_ready to drive in that cycle
  int         exp_count;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control values each state must present, straight from the state table
  function automatic logic [17:0] exp_ctrl(input int s, input logic r, input logic [5:0] f);
    logic mr = 0, mw = 0, iod = 0, irw = 0, pcw = 0, pcc = 0;
    logic rw = 0, rd = 0, m2r = 0, asa = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [3:0] ac = 0;
    case (s)
      S_FETCH:   begin mr = 1; asb = 2'b01; ac = 4'b0010; irw = r; pcw = r; end
      S_DECODE:  begin asb = 2'b11; ac = 4'b0010; end
      S_MEMADR:  begin asa = 1; asb = 2'b10; ac = 4'b0010; end
      S_MEMRD:   begin mr = 1; iod = 1; end
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin mw = 1; iod = 1; end
      S_EXEC: begin
        asa = 1;
        case (f)
          6'h20: ac = 4'b0010;
          6'h22: ac = 4'b0110;
          6'h24: ac = 4'b0000;
          6'h25: ac = 4'b0001;
          6'h2a: ac = 4'b0111;
          default: ac = 4'bxxxx;
        endcase
      end
      S_RWB:     begin rw = 1; rd = 1; end
      S_BRANCH:  begin asa = 1; ac = 4'b0110; pcc = 1; pcs = 2'b01; end
      S_JUMP:    begin pcw = 1; pcs = 2'b10; end
      S_ADDI_EX: begin asa = 1; asb = 2'b10; ac = 4'b0010; end
      S_ADDI_WB: begin rw = 1; end
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pcc, rw, rd, m2r, asa, asb, ac, pcs};
  endfunction

  // ---------------- trace builders (reference model) ----------------
  task automatic push_fixed(input int s);
    exp_q.push_back(4'(s));
    exp_rdy_q.push_back(1'($urandom_range(0, 1)));  // ready ignored here
  endtask

  // Memory state: w stalled cycles, then a completing cycle
  task automatic push_wait(input int s, input int w);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back(4'(s));
      exp_rdy_q.push_back(1'b0);
    end
    exp_q.push_back(4'(s));
    exp_rdy_q.push_back(1'b1);
  endtask

  task automatic push_stall(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(4'(s));
      exp_rdy_q.push_back(1'b0);
    end
  endtask

  // kind 0-4 R-type, 5 lw, 6 sw, 7 beq, 8 j, 9 addi
  task automatic gen_instr(input int k, input int wf, input int wm);
    logic [5:0] r_functs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    bus.funct = 6'($urandom_range(0, 63));
    push_wait(S_FETCH, wf);
    push_fixed(S_DECODE);
    if (k <= 4) begin
      bus.opcode = 6'h00; bus.funct = r_functs[k];
      push_fixed(S_EXEC); push_fixed(S_RWB);
    end else if (k == 5) begin
      bus.opcode = 6'h23;
      push_fixed(S_MEMADR); push_wait(S_MEMRD, wm); push_fixed(S_MEMWB);
    end else if (k == 6) begin
      bus.opcode = 6'h2b;
      push_fixed(S_MEMADR); push_wait(S_MEMWR, wm);
    end else if (k == 7) begin
      bus.opcode = 6'h04; push_fixed(S_BRANCH);
    end else if (k == 8) begin
      bus.opcode = 6'h02; push_fixed(S_JUMP);
    end else begin
      bus.opcode = 6'h08; push_fixed(S_ADDI_EX); push_fixed(S_ADDI_WB);
    end
    exp_count = (exp_count + 1) % 65536;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at posedge+1 after the last traced cycle.
  task automatic run_trace(input string tag);
    logic [3:0] s;
    logic r;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      r = exp_rdy_q.pop_front();
      bus.mem_ready = r;
      bus.start = ($urandom_range(0, 3) == 0);  // must be ignored outside IDLE
      @(negedge clk);
      check({tag, " state"}, 32'(state), 32'(s));
      check({tag, " ctrl"}, 32'(ctrl_vec), 32'(exp_ctrl(int'(s), r, bus.funct)));
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic ill, input logic tmo);
    check({tag, " count"}, 32'(instr_count), 32'(exp_count));
    check({tag, " err_illegal"}, 32'(err_illegal), 32'(ill));
    check({tag, " err_timeout"}, 32'(err_timeout), 32'(tmo));
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(negedge clk);
    check("idle before start", 32'(state), S_IDLE);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;  // no clock edge in between: asynchronous effect
    check("reset state", 32'(state), S_IDLE);
    check("reset ctrl", 32'(ctrl_vec), 32'(0));
    exp_count = 0;
    check_status("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_halt_tail(input string tag);
    push_fixed(S_HALT); push_fixed(S_HALT); push_fixed(S_HALT);
    run_trace(tag);
    bus.start = 1'b1;
    @(negedge clk);
    check({tag, " start ignored"}, 32'(state), S_HALT);
    check({tag, " halt ctrl"}, 32'(ctrl_vec), 32'(0));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.mem_ready = 1'b0;
    exp_count = 0;

    @(negedge clk);
    check("por state", 32'(state), S_IDLE);
    check("por ctrl", 32'(ctrl_vec), 32'(0));
    check_status("por", 1'b0, 1'b0);
    reset = 1'b0;

    // add, zero-wait: 1,2,7,8
    start_pulse();
    gen_instr(0, 0, 0);
    run_trace("add");
    check_status("add", 1'b0, 1'b0);

    // lw with two stalled MEMRD cycles: 7 cycles
    gen_instr(5, 0, 2);
    run_trace("lw");
    check_status("lw", 1'b0, 1'b0);

    // beq then j
    gen_instr(7, 0, 0);
    run_trace("beq");
    gen_instr(8, 0, 0);
    run_trace("j");
    check_status("beq_j", 1'b0, 1'b0);

    // randomized program with random memory stalls
    for (int i = 0; i < 60; i++) begin
      gen_instr($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 4));
      run_trace("rand");
      check_status("rand", 1'b0, 1'b0);
    end

    // illegal opcode
    push_wait(S_FETCH, 0);
    push_fixed(S_DECODE);
    bus.opcode = 6'h3f;
    run_halt_tail("ill_op");
    check_status("ill_op", 1'b1, 1'b0);

    // illegal R-type funct
    do_reset();
    start_pulse();
    bus.opcode = 6'h00;
    bus.funct = 6'h21;
    push_wait(S_FETCH, 0);
    push_fixed(S_DECODE);
    run_halt_tail("ill_fn");
    check_status("ill_fn", 1'b1, 1'b0);

    // fetch timeout: 15 low cycles, never ir_write
    do_reset();
    start_pulse();
    push_stall(S_FETCH, 15);
    run_halt_tail("tmo_fetch");
    check_status("tmo_fetch", 1'b0, 1'b1);

    // ready arrives on the 15th cycle: normal advance
    do_reset();
    start_pulse();
    gen_instr(2, 14, 0);
    run_trace("late_rdy");
    check_status("late_rdy", 1'b0, 1'b0);

    // store with maximum legal stall, then a load that times out
    gen_instr(6, 3, 14);
    run_trace("sw_late");
    check_status("sw_late", 1'b0, 1'b0);
    bus.opcode = 6'h23;
    push_wait(S_FETCH, 1);
    push_fixed(S_DECODE);
    push_fixed(S_MEMADR);
    push_stall(S_MEMRD, 15);
    run_halt_tail("tmo_memrd");
    check_status("tmo_memrd", 1'b0, 1'b1);

    // reset in the middle of a store
    do_reset();
    start_pulse();
    gen_instr(9, 0, 0);
    run_trace("addi");
    check_status("addi", 1'b0, 1'b0);
    bus.opcode = 6'h2b;
    push_wait(S_FETCH, 0);
    push_fixed(S_DECODE);
    push_fixed(S_MEMADR);
    run_trace("sw_pre");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memwr state", 32'(state), S_MEMWR);
    check("memwr strobe", 32'(bus.mem_write), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("rst memwr strobe", 32'(bus.mem_write), 32'(0));
    check("rst memwr state", 32'(state), S_IDLE);
    exp_count = 0;
    check("rst memwr count", 32'(instr_count), 32'(exp_count));
    @(negedge clk);
    reset = 1'b0;

    // machine restarts cleanly after the abandoned store
    start_pulse();
    gen_instr(4, 1, 0);
    run_trace("after_rst");
    check_status("after_rst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
